// File: rtl/tc_serial_decoder_pkg.sv
// Shared constants for the bit-serial two's-complement to sign-magnitude decoder.
// This package holds the default width, the FSM encoding and the counter sizing helper.
package tc_pkg;

  localparam int WIDTH_DEF = 8;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/tc_serial_decoder_if.sv
// Request/result bundle between the encoder datapath and the serial decoder.
// The master drives the operand and start; the slave returns status and the result.
interface tc_serial_decoder_if
  import tc_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic             start;
  logic [WIDTH-1:0] tc_in;
  logic             busy;
  logic             done;
  logic             sign;
  logic [WIDTH-1:0] mag;
  logic             ovf;

  modport master (output start, tc_in, input busy, done, sign, mag, ovf);
  modport slave  (input start, tc_in, output busy, done, sign, mag, ovf);

endinterface

// File: rtl/tc_serial_decoder_negate_bit.sv
// One bit of serial negation: copy bits up to and including the first 1, invert after it.
// The seen_one flag replaces a carry chain, so there is no ripple path.
module tc_serial_negate_bit (
  input  logic b_i,
  input  logic negate_i,
  input  logic seen_one_i,
  output logic ob_o,
  output logic seen_one_o
);

  assign ob_o       = (negate_i & seen_one_i) ? ~b_i : b_i;
  assign seen_one_o = seen_one_i | b_i;

endmodule

// File: rtl/tc_serial_decoder.sv
// Bit-serial two's-complement to sign-magnitude decoder, LSB first, fixed WIDTH-cycle latency.
// Results are registered at completion and held until the next completion.
module tc_serial_decoder
  import tc_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input logic              clk,
  input logic              rst_n,
  tc_serial_decoder_if.slave bus
);

  localparam int CNT_W = clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             seen_q, seen_d;
  logic             sign_w_q, sign_w_d;
  logic             sign_q, sign_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic             ovf_q, ovf_d;

  logic             ob;
  logic             seen_nxt;

  tc_serial_negate_bit u_negate_bit (
    .b_i        (sreg_q[0]),
    .negate_i   (sign_w_q),
    .seen_one_i (seen_q),
    .ob_o       (ob),
    .seen_one_o (seen_nxt)
  );

  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    seen_d   = seen_q;
    sign_w_d = sign_w_q;
    sign_d   = sign_q;
    mag_d    = mag_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          sreg_d   = bus.tc_in;
          sign_w_d = bus.tc_in[WIDTH-1];
          cnt_d    = '0;
          seen_d   = 1'b0;
          state_d  = SHIFT;
        end else begin
          state_d  = IDLE;
        end
      end
      SHIFT: begin
        // start is deliberately not looked at here: no queueing of a new operand.
        sreg_d = sreg_q >> 1;
        acc_d  = {ob, acc_q[WIDTH-1:1]};
        seen_d = seen_nxt;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          mag_d   = acc_d;
          sign_d  = sign_w_q;
          ovf_d   = sign_w_q & (acc_d == MOST_NEG);
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sreg_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      seen_q   <= 1'b0;
      sign_w_q <= 1'b0;
      sign_q   <= 1'b0;
      mag_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sreg_q   <= sreg_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      seen_q   <= seen_d;
      sign_w_q <= sign_w_d;
      sign_q   <= sign_d;
      mag_q    <= mag_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.busy = (state_q == SHIFT);
  assign bus.done = (state_q == DONE);
  assign bus.sign = sign_q;
  assign bus.mag  = mag_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_tc_serial_decoder.sv
// Directed bench for tc_serial_decoder at WIDTH=8 with hand-computed expected results.
module tb_tc_serial_decoder;

  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;

  tc_serial_decoder_if #(.WIDTH(W)) bus ();

  tc_serial_decoder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present an operand with a one-cycle start; returns just after the accepting edge.
  task automatic launch(input logic [W-1:0] v);
    bus.tc_in = v;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  // Waits for done (bounded) and checks latency, busy cycles and the result; leaves DUT in DONE.
  task automatic wait_done(input string tag, input int exp_lat, input logic exp_sign,
                           input logic [W-1:0] exp_mag, input logic exp_ovf);
    int lat;
    int nb;
    lat = 0;
    nb  = 0;
    while (!bus.done && lat < 20) begin
      if (bus.busy) nb++;
      step();
      lat++;
    end
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " busy_cycles"}, nb, exp_lat);
    chk({tag, " busy_in_done"}, bus.busy, 1'b0);
    chk({tag, " sign"}, bus.sign, exp_sign);
    chk({tag, " mag"}, bus.mag, exp_mag);
    chk({tag, " ovf"}, bus.ovf, exp_ovf);
  endtask

  // Leaves DONE with start low and confirms the pulse ended while the result holds.
  task automatic finish_idle(input string tag, input logic exp_sign, input logic [W-1:0] exp_mag);
    step();
    chk({tag, " done_pulse"}, bus.done, 1'b0);
    chk({tag, " hold_mag"}, bus.mag, exp_mag);
    chk({tag, " hold_sign"}, bus.sign, exp_sign);
  endtask

  initial begin
    int ndone;
    n_assert  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.tc_in = '0;
    step();
    step();
    chk("rst busy", bus.busy, 1'b0);
    chk("rst done", bus.done, 1'b0);
    chk("rst mag", bus.mag, 8'd0);
    rst_n = 1'b1;
    step();
    chk("idle sign", bus.sign, 1'b0);
    chk("idle ovf", bus.ovf, 1'b0);

    launch(8'h05);
    chk("05 busy_after_start", bus.busy, 1'b1);
    wait_done("05", 8, 1'b0, 8'd5, 1'b0);
    finish_idle("05", 1'b0, 8'd5);

    launch(8'hFB);
    wait_done("FB", 8, 1'b1, 8'd5, 1'b0);
    finish_idle("FB", 1'b1, 8'd5);

    launch(8'hFF);
    wait_done("FF", 8, 1'b1, 8'd1, 1'b0);
    finish_idle("FF", 1'b1, 8'd1);

    launch(8'h00);
    wait_done("00", 8, 1'b0, 8'd0, 1'b0);
    finish_idle("00", 1'b0, 8'd0);

    launch(8'h80);
    wait_done("80", 8, 1'b1, 8'd128, 1'b1);
    finish_idle("80", 1'b1, 8'd128);

    // Asynchronous abort in the middle of a conversion.
    launch(8'hFB);
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort busy", bus.busy, 1'b0);
    chk("abort done", bus.done, 1'b0);
    chk("abort sign", bus.sign, 1'b0);
    chk("abort mag", bus.mag, 8'd0);
    chk("abort ovf", bus.ovf, 1'b0);
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.done) ndone++;
    end
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.done) ndone++;
    end
    chk("abort no_done", ndone, 0);
    chk("abort idle_busy", bus.busy, 1'b0);

    launch(8'h7F);
    wait_done("7F", 8, 1'b0, 8'd127, 1'b0);
    finish_idle("7F", 1'b0, 8'd127);

    // Second start during SHIFT must be ignored.
    launch(8'hF0);
    step();
    step();
    bus.tc_in = 8'h01;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_done("F0", 5, 1'b1, 8'd16, 1'b0);
    finish_idle("F0", 1'b1, 8'd16);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.done) ndone++;
    end
    chk("F0 single_done", ndone, 0);

    // Back-to-back: restart in the DONE cycle.
    launch(8'h9C);
    wait_done("9C", 8, 1'b1, 8'd100, 1'b0);
    launch(8'h64);
    chk("64 busy_b2b", bus.busy, 1'b1);
    chk("64 hold_prev_mag", bus.mag, 8'd100);
    chk("64 hold_prev_sign", bus.sign, 1'b1);
    wait_done("64", 8, 1'b0, 8'd100, 1'b0);
    finish_idle("64", 1'b0, 8'd100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
